count_ctrl_fsm: RTL and testbench

//  Command/timing controller that sits directly upstream of the up-counter.
//  - Turns start/stop/clear commands into the counter's c_up and clr strobes.
//  - Paces c_up with an internal prescaler.
//  - Watches the counter value and stops counting once it reaches a programmed limit.

---
 rtl/count_ctrl_fsm_pkg.sv | 13 +
 rtl/edge_detect.sv | 18 +
 rtl/count_ctrl_fsm.sv | 112 +++++++++++
 tb/tb_count_ctrl_fsm.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_fsm_pkg.sv
// Shared definitions for the counter command/timing controller.
package count_ctrl_fsm_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one registered history bit, combinational rise strobe.
module edge_detect (
  input  logic clk,
  input  logic rst_b,
  input  logic x,
  output logic rise
);

  logic x_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) x_d <= 1'b0;
    else        x_d <= x;
  end

  assign rise = x & ~x_d;

endmodule

// File: rtl/count_ctrl_fsm.sv
// Command/timing controller upstream of the up-counter: paces c_up with a
// prescaler, issues clr strobes, and stops once cnt_q reaches LIMIT.
module count_ctrl_fsm
  import count_ctrl_fsm_pkg::*;
#(
  parameter int unsigned      width    = 8,
  parameter int unsigned      PRESCALE = 4,
  parameter logic [width-1:0] LIMIT    = width'(8'h03)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [width-1:0] cnt_q,
  output logic             c_up,
  output logic             clr,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic rise_start, rise_stop, rise_clear;

  edge_detect u_start (.clk(clk), .rst_b(rst_b), .x(start), .rise(rise_start));
  edge_detect u_stop  (.clk(clk), .rst_b(rst_b), .x(stop),  .rise(rise_stop));
  edge_detect u_clear (.clk(clk), .rst_b(rst_b), .x(clear), .rise(rise_clear));

  state_t        state, state_nx;
  logic [PW-1:0] pres, pres_nx;
  logic          c_up_nx, clr_nx, busy_nx, done_nx;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      pres  <= '0;
      c_up  <= 1'b0;
      clr   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      pres  <= pres_nx;
      c_up  <= c_up_nx;
      clr   <= clr_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pres_nx  = pres;
    c_up_nx  = 1'b0;
    clr_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise_clear) begin
          clr_nx  = 1'b1;
          pres_nx = '0;
        end else if (rise_start) begin
          state_nx = RUN;
          pres_nx  = '0;
        end
      end
      RUN: begin
        if (rise_clear) begin
          state_nx = IDLE;
          clr_nx   = 1'b1;
          pres_nx  = '0;
        end else if (cnt_q == LIMIT) begin
          state_nx = DONE;
        end else begin
          // The stop cycle still counts as a RUN cycle, so the prescaler
          // advances once more before being held in PAUSE.
          if (pres == PRE_LAST) begin
            c_up_nx = 1'b1;
            pres_nx = '0;
          end else begin
            pres_nx = pres + 1'b1;
          end
          if (rise_stop) state_nx = PAUSE;
        end
      end
      PAUSE: begin
        if (rise_clear) begin
          state_nx = IDLE;
          clr_nx   = 1'b1;
          pres_nx  = '0;
        end else if (rise_start) begin
          state_nx = RUN;
        end
      end
      DONE: begin
        if (rise_clear) begin
          state_nx = IDLE;
          clr_nx   = 1'b1;
          pres_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        pres_nx  = '0;
      end
    endcase
    busy_nx = (state_nx == RUN) || (state_nx == PAUSE);
    done_nx = (state_nx == DONE);
  end

endmodule

// File: tb/tb_count_ctrl_fsm.sv
// Bench for count_ctrl_fsm driving a modelled up-counter (reset/clear value ff).
module tb_count_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] cnt;
  logic       c_up, clr, busy, done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int upq[$];
  int clrq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)    cnt <= 8'hff;
    else if (clr)  cnt <= 8'hff;
    else if (c_up) cnt <= cnt + 8'd1;
  end

  count_ctrl_fsm #(.width(8), .PRESCALE(4), .LIMIT(8'h03)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .stop(stop), .clear(clear),
    .cnt_q(cnt), .c_up(c_up), .clr(clr), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every c_up / clr pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (c_up) begin
      chk("c_up_expected", 32'(upq.size() != 0), 1);
      if (upq.size() != 0) chk("c_up_cycle", cyc, upq.pop_front());
    end
    if (clr) begin
      chk("clr_expected", 32'(clrq.size() != 0), 1);
      if (clrq.size() != 0) chk("clr_cycle", cyc, clrq.pop_front());
    end
    chk("c_up_clr_excl", 32'(c_up & clr), 0);
    chk("busy_done_excl", 32'(busy & done), 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_full(input string tag);
    int k;
    k = cyc;
    start = 1'b1;
    for (int i = 0; i < 4; i++) upq.push_back(k + 5 + 4 * i);
    tick(1);
    start = 1'b0;
    chk({tag, "_busy_entry"}, 32'(busy), 1);
    tick(9);
    chk({tag, "_cnt_mid"}, 32'(cnt), 8'h01);
    tick(8);
    chk({tag, "_busy_at_limit"}, 32'(busy), 1);
    chk({tag, "_cnt_at_limit"}, 32'(cnt), 8'h03);
    tick(1);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_done"}, 32'(busy), 0);
    chk({tag, "_pulses_all"}, upq.size(), 0);
    tick(6);
    chk({tag, "_cnt_hold"}, 32'(cnt), 8'h03);
    chk({tag, "_done_hold"}, 32'(done), 1);
  endtask

  task automatic do_clear(input string tag);
    int k;
    k = cyc;
    clear = 1'b1;
    clrq.push_back(k + 1);
    tick(1);
    clear = 1'b0;
    chk({tag, "_clr"}, 32'(clr), 1);
    chk({tag, "_done0"}, 32'(done), 0);
    chk({tag, "_busy0"}, 32'(busy), 0);
    tick(1);
    chk({tag, "_cnt_ff"}, 32'(cnt), 8'hff);
    chk({tag, "_clr_seen"}, clrq.size(), 0);
  endtask

  initial begin
    int k;
    int r;

    // Reset state
    tick(2);
    chk("rst_c_up", 32'(c_up), 0);
    chk("rst_clr", 32'(clr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_b = 1'b1;
    tick(2);

    // 1: async reset while c_up is high
    k = cyc;
    start = 1'b1;
    upq.push_back(k + 5);
    tick(1);
    start = 1'b0;
    tick(4);
    chk("s1_c_up_high", 32'(c_up), 1);
    @(negedge clk);
    #1 rst_b = 1'b0;
    #1;
    chk("s1_async_c_up", 32'(c_up), 0);
    chk("s1_async_busy", 32'(busy), 0);
    chk("s1_async_done", 32'(done), 0);
    chk("s1_async_clr", 32'(clr), 0);
    tick(2);
    rst_b = 1'b1;
    tick(3);
    chk("s1_idle_busy", 32'(busy), 0);
    chk("s1_no_more_pulses", upq.size(), 0);

    // 2: full count ff -> 03
    run_full("s2");

    // 6: commands in DONE
    start = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(4);
    chk("s6_done_keep", 32'(done), 1);
    chk("s6_busy_keep", 32'(busy), 0);
    chk("s6_cnt_keep", 32'(cnt), 8'h03);
    do_clear("s6_clear");
    run_full("s6_rerun");
    do_clear("s6_clear2");

    // 3: pause after two RUN cycles, resume after 10 clk
    k = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("s3_paused_busy", 32'(busy), 1);
    tick(10);
    chk("s3_pause_busy", 32'(busy), 1);
    chk("s3_pause_cnt", 32'(cnt), 8'hff);
    r = cyc;
    start = 1'b1;
    for (int i = 0; i < 4; i++) upq.push_back(r + 3 + 4 * i);
    tick(1);
    start = 1'b0;
    tick(16);
    chk("s3_done", 32'(done), 1);
    chk("s3_cnt", 32'(cnt), 8'h03);
    chk("s3_pulses_all", upq.size(), 0);
    do_clear("s3_clear");

    // 4: clear coinciding with a due c_up
    k = cyc;
    start = 1'b1;
    upq.push_back(k + 5);
    tick(1);
    start = 1'b0;
    tick(7);
    clear = 1'b1;
    clrq.push_back(k + 9);
    tick(1);
    clear = 1'b0;
    chk("s4_clr", 32'(clr), 1);
    chk("s4_c_up_suppressed", 32'(c_up), 0);
    chk("s4_busy", 32'(busy), 0);
    tick(1);
    chk("s4_cnt_ff", 32'(cnt), 8'hff);
    tick(10);
    chk("s4_idle_busy", 32'(busy), 0);
    chk("s4_queue_up", upq.size(), 0);

    // 5: start and clear together in IDLE, start held
    k = cyc;
    start = 1'b1;
    clear = 1'b1;
    clrq.push_back(k + 1);
    tick(1);
    clear = 1'b0;
    chk("s5_clr", 32'(clr), 1);
    tick(20);
    chk("s5_busy", 32'(busy), 0);
    chk("s5_done", 32'(done), 0);
    chk("s5_cnt", 32'(cnt), 8'hff);
    start = 1'b0;
    tick(2);

    chk("end_up_queue", upq.size(), 0);
    chk("end_clr_queue", clrq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
